// File: rtl/jtag_scan_master.sv
// Fabric-side JTAG initiator: turns TLR / IR-scan / DR-scan / idle commands into
// complete TAP pin sequences and returns the captured TDO bits.
`timescale 1ns/1ps
module jtag_scan_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  output logic               jtag_trst_n,
  input  logic               jtag_tdo
);

  typedef enum logic [2:0] {
    S_AUTORST, S_IDLE, S_RESET, S_PRE, S_SHIFT, S_POST, S_RUN, S_RESP
  } state_e;

  typedef enum logic [1:0] {OP_TLR = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_RUN = 2'd3} op_e;

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [6:0]    LEN_MAX  = 7'(MAX_LEN);

  state_e               state_q;
  op_e                  op_q;
  logic [6:0]           len_q, idx_q;
  logic [DW-1:0]        div_q;
  logic                 tck_q, tms_q, tdi_q, trst_n_q;
  logic [MAX_LEN-1:0]   data_q, mask_q, rsp_q;
  logic                 cmd_ready_q, rsp_valid_q, busy_q;

  logic                 bit_active, rise, fall;
  logic [6:0]           len_clamped;
  state_e               nxt_state;
  logic [6:0]           nxt_idx;
  logic                 nxt_tms, nxt_tdi, nxt_trst_n;

  assign bit_active  = state_q inside {S_AUTORST, S_RESET, S_PRE, S_SHIFT, S_POST, S_RUN};
  assign rise        = bit_active && !tck_q && (div_q == DIV_LAST);
  assign fall        = bit_active &&  tck_q && (div_q == DIV_LAST);
  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  // Where the sequence goes once the current bit ends.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nxt_state = state_q;
    nxt_idx   = idx_q + 7'd1;
    case (state_q)
      S_AUTORST: if (idx_q == 7'd6) begin nxt_state = S_IDLE; nxt_idx = '0; end
      S_RESET:   if (idx_q == 7'd6) begin nxt_state = S_RESP; nxt_idx = '0; end
      S_PRE:     if (idx_q == ((op_q == OP_IR) ? 7'd3 : 7'd2)) begin
                   nxt_state = S_SHIFT; nxt_idx = '0;
                 end
      S_SHIFT:   if (idx_q == len_q - 7'd1) begin nxt_state = S_POST; nxt_idx = '0; end
      S_POST:    if (idx_q == 7'd1) begin nxt_state = S_RESP; nxt_idx = '0; end
      S_RUN:     if (idx_q == len_q - 7'd1) begin nxt_state = S_RESP; nxt_idx = '0; end
      default:   ;
    endcase
  end

  // Pin levels for the bit that starts at this TCK fall (idle levels otherwise).
  always_comb begin
    nxt_tms    = 1'b1;
    nxt_tdi    = 1'b0;
    nxt_trst_n = 1'b1;
    case (nxt_state)
      S_AUTORST, S_RESET: begin
        nxt_tms    = (nxt_idx < 7'd6);
        nxt_trst_n = (nxt_idx >= 7'd2);
      end
      S_PRE:   nxt_tms = (op_q == OP_IR) ? (nxt_idx < 7'd2) : (nxt_idx == 7'd0);
      S_SHIFT: begin
        nxt_tms = (nxt_idx == len_q - 7'd1);
        // data_q shifts on this same edge, so a continuing scan looks one bit ahead.
        nxt_tdi = (state_q == S_SHIFT) ? data_q[1] : data_q[0];
      end
      S_POST:  nxt_tms = (nxt_idx == 7'd0);
      S_RUN:   nxt_tms = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_AUTORST;
      op_q        <= OP_TLR;
      len_q       <= '0;
      idx_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      // NOTE: state and every registered output use non-blocking assignments so all
      // decisions in this edge see the pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            op_q        <= op_e'(cmd_op);
            len_q       <= len_clamped;
            data_q      <= cmd_data;
            mask_q      <= MAX_LEN'(1);
            rsp_q       <= '0;
            idx_q       <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            case (op_e'(cmd_op))
              OP_TLR: begin
                state_q  <= S_RESET;
                tms_q    <= 1'b1;
                trst_n_q <= 1'b0;
              end
              OP_IR, OP_DR: begin
                if (len_clamped == 7'd0) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                end else begin
                  state_q <= S_PRE;
                  tms_q   <= 1'b1;
                end
              end
              default: begin
                if (len_clamped == 7'd0) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                end else begin
                  state_q <= S_RUN;
                  tms_q   <= 1'b0;
                end
              end
            endcase
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          if (rise) begin
            tck_q <= 1'b1;
            div_q <= '0;
            if (state_q == S_SHIFT && jtag_tdo) rsp_q <= rsp_q | mask_q;
          end else if (fall) begin
            tck_q    <= 1'b0;
            div_q    <= '0;
            state_q  <= nxt_state;
            idx_q    <= nxt_idx;
            tms_q    <= nxt_tms;
            tdi_q    <= nxt_tdi;
            trst_n_q <= nxt_trst_n;
            if (state_q == S_SHIFT) begin
              data_q <= data_q >> 1;
              mask_q <= mask_q << 1;
            end
            if (nxt_state == S_RESP) rsp_valid_q <= 1'b1;
            if (nxt_state == S_IDLE) begin
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_q;
  assign busy        = busy_q;
  assign jtag_tck    = tck_q;
  assign jtag_tms    = tms_q;
  assign jtag_tdi    = tdi_q;
  assign jtag_trst_n = trst_n_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural TAP (5-bit IR, IDCODE/BYPASS) answers the
// master; directed command vectors plus reset, backpressure and abort sequences.
`timescale 1ns/1ps
module tb_jtag_scan_master;
  localparam int          CLK_DIV = 4;
  localparam int          MAX_LEN = 64;
  localparam logic [31:0] IDCODE  = 32'h249511C3;
  localparam logic [63:0] D1      = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D2      = 64'h0F0F_1234_CAFE_5A5A;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = '0;
  logic [6:0]         cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
  logic               jtag_tdo = 1'b0;

  always #5 aclk = ~aclk;

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_trst_n(jtag_trst_n), .jtag_tdo(jtag_tdo)
  );

  // ---------------- behavioural TAP ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e        tap_st = TLR;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  ir_sr  = '0;
  logic [31:0] dr_sr  = '0;

  always @(posedge jtag_tck or negedge jtag_trst_n) begin
    if (!jtag_trst_n) begin
      tap_st <= TLR;
      tap_ir <= 5'h01;
    end else begin
      case (tap_st)
        TLR:    begin tap_st <= jtag_tms ? TLR : RTI; tap_ir <= 5'h01; end
        RTI:    tap_st <= jtag_tms ? SEL_DR : RTI;
        SEL_DR: tap_st <= jtag_tms ? SEL_IR : CAP_DR;
        CAP_DR: begin
          tap_st <= jtag_tms ? EX1_DR : SH_DR;
          dr_sr  <= (tap_ir == 5'h01) ? IDCODE : 32'h0;
        end
        SH_DR: begin
          tap_st <= jtag_tms ? EX1_DR : SH_DR;
          if (tap_ir == 5'h01) dr_sr <= {jtag_tdi, dr_sr[31:1]};
          else                 dr_sr[0] <= jtag_tdi;
        end
        EX1_DR: tap_st <= jtag_tms ? UPD_DR : PAU_DR;
        PAU_DR: tap_st <= jtag_tms ? EX2_DR : PAU_DR;
        EX2_DR: tap_st <= jtag_tms ? UPD_DR : SH_DR;
        UPD_DR: tap_st <= jtag_tms ? SEL_DR : RTI;
        SEL_IR: tap_st <= jtag_tms ? TLR : CAP_IR;
        CAP_IR: begin tap_st <= jtag_tms ? EX1_IR : SH_IR; ir_sr <= 5'h01; end
        SH_IR:  begin tap_st <= jtag_tms ? EX1_IR : SH_IR; ir_sr <= {jtag_tdi, ir_sr[4:1]}; end
        EX1_IR: tap_st <= jtag_tms ? UPD_IR : PAU_IR;
        PAU_IR: tap_st <= jtag_tms ? EX2_IR : PAU_IR;
        EX2_IR: tap_st <= jtag_tms ? UPD_IR : SH_IR;
        UPD_IR: begin tap_st <= jtag_tms ? SEL_DR : RTI; tap_ir <= ir_sr; end
        default: tap_st <= TLR;
      endcase
    end
  end

  always @(negedge jtag_tck or negedge jtag_trst_n) begin
    if (!jtag_trst_n)         jtag_tdo <= 1'b0;
    else if (tap_st == SH_DR) jtag_tdo <= dr_sr[0];
    else if (tap_st == SH_IR) jtag_tdo <= ir_sr[0];
    else                      jtag_tdo <= 1'b0;
  end

  // ---------------- pin monitors ----------------
  logic tms_log[$];
  logic tdi_log[$];
  logic trst_log[$];
  time  rise_t[$];
  time  fall_t[$];
  int   rsp_hi_cyc = 0;

  always @(posedge jtag_tck) begin
    tms_log.push_back(jtag_tms);
    tdi_log.push_back(jtag_tdi);
    trst_log.push_back(jtag_trst_n);
    rise_t.push_back($time);
  end
  always @(negedge jtag_tck) fall_t.push_back($time);
  always @(negedge aclk) if (rsp_valid) rsp_hi_cyc++;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!cmd_ready && t < 3000) begin @(negedge aclk); t++; end
    check({name, " cmd_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [6:0] len,
                         input logic [63:0] data, output logic [63:0] rsp, output int lat);
    wait_ready(name);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_data = '0;
    lat = 0;
    while (!rsp_valid && lat < 3000) begin @(negedge aclk); lat++; end
    check({name, " rsp_valid"}, rsp_valid, 1'b1);
    rsp = rsp_data;
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  len;
    logic [63:0] data;
    logic [63:0] exp_rsp;
    int          exp_tck;
    logic [4:0]  exp_ir;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    logic [63:0] rsp, held;
    logic [10:0] tms_seq;
    logic [6:0]  seq7, trst7;
    logic [4:0]  tdi_seq;
    logic        ok, done;
    int          lat, b, fb, n, hi0;

    // op, len, data, expected rsp, expected TCK rises, TAP IR afterwards
    vecs[0] = '{2'd2, 7'd32,  64'h0,  {32'h0, IDCODE},        37, 5'h01};
    vecs[1] = '{2'd1, 7'd5,   64'h11, 64'h01,                 11, 5'h11};
    vecs[2] = '{2'd2, 7'd0,   64'hFF, 64'h0,                   0, 5'h11};
    vecs[3] = '{2'd2, 7'd100, D1,     D1 << 1,                69, 5'h11};
    vecs[4] = '{2'd3, 7'd5,   64'hFF, 64'h0,                   5, 5'h11};
    vecs[5] = '{2'd3, 7'd0,   64'h0,  64'h0,                   0, 5'h11};
    vecs[6] = '{2'd0, 7'd3,   64'hFF, 64'h0,                   7, 5'h01};
    vecs[7] = '{2'd2, 7'd64,  D2,     (D2 << 32) | 64'(IDCODE), 69, 5'h01};
    vecs[8] = '{2'd1, 7'd5,   64'h1F, 64'h01,                 11, 5'h1F};
    vecs[9] = '{2'd2, 7'd8,   64'hA5, 64'h4A,                 13, 5'h1F};

    // reset values
    repeat (3) @(negedge aclk);
    check("reset pins/flags {tck,tms,tdi,trst_n,cmd_ready,rsp_valid,busy}",
          {jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n, cmd_ready, rsp_valid, busy}, 7'b0100001);
    check("reset rsp_data", rsp_data, 64'h0);

    // AUTORST after release
    b = tms_log.size(); fb = fall_t.size();
    aresetn = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 100) begin @(posedge aclk); #1; n++; done = jtag_trst_n; end
    check("autorst trst_n low cycles", n, 16);
    @(negedge aclk);
    wait_ready("autorst");
    check("autorst tck rises", tms_log.size() - b, 7);
    for (int k = 0; k < 7; k++) begin
      seq7[6-k]  = tms_log[b+k];
      trst7[6-k] = trst_log[b+k];
    end
    check("autorst tms seq", seq7, 7'b1111110);
    check("autorst trst_n at rises", trst7, 7'b0011111);
    check("tck period ns", rise_t[b+1] - rise_t[b], 64'd80);
    check("tck high ns", fall_t[fb] - rise_t[b], 64'd40);
    check("autorst tap in RTI", tap_st, RTI);
    check("autorst busy", busy, 1'b0);

    // table-driven commands
    for (int i = 0; i < NV; i++) begin
      b = tms_log.size();
      run_cmd($sformatf("v%0d", i), vecs[i].op, vecs[i].len, vecs[i].data, rsp, lat);
      check($sformatf("v%0d rsp_data", i), rsp, vecs[i].exp_rsp);
      check($sformatf("v%0d tck rises", i), tms_log.size() - b, vecs[i].exp_tck);
      check($sformatf("v%0d tap ir", i), tap_ir, vecs[i].exp_ir);
      check($sformatf("v%0d tap state", i), tap_st, RTI);
      if (vecs[i].exp_tck == 0) check($sformatf("v%0d zero-len latency ok", i), lat <= 2, 1'b1);
    end

    // backpressure: response held for 10 cycles, queued command ignored until after handshake
    wait_ready("bp");
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 7'd8; cmd_data = 64'hA5;
    @(negedge aclk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge aclk); n++; end
    check("bp rsp_valid", rsp_valid, 1'b1);
    held = rsp_data;
    check("bp rsp_data", held, 64'h4A);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 7'd3; cmd_data = '0;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      if (!rsp_valid || rsp_data !== held || cmd_ready || !busy) ok = 1'b0;
    end
    check("bp held stable", ok, 1'b1);
    b = tms_log.size();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("bp after handshake {cmd_ready,busy,rsp_valid}", {cmd_ready, busy, rsp_valid}, 3'b100);
    @(negedge aclk);
    cmd_valid = 1'b0;
    check("bp queued cmd taken {cmd_ready,busy}", {cmd_ready, busy}, 2'b01);
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge aclk); n++; end
    check("bp run rsp", rsp_data, 64'h0);
    check("bp run tck rises", tms_log.size() - b, 3);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;

    // IR scan pin sequence
    b = tms_log.size();
    run_cmd("ir11", 2'd1, 7'd5, 64'h11, rsp, lat);
    check("ir11 tck rises", tms_log.size() - b, 11);
    for (int k = 0; k < 11; k++) tms_seq[10-k] = tms_log[b+k];
    for (int k = 0; k < 5; k++)  tdi_seq[4-k]  = tdi_log[b+4+k];
    check("ir11 tms seq", tms_seq, 11'b11000000110);
    check("ir11 tdi seq", tdi_seq, 5'b10001);
    check("ir11 tap ir", tap_ir, 5'h11);
    check("idle pins {tck,tms,tdi}", {jtag_tck, jtag_tms, jtag_tdi}, 3'b010);

    // abort mid DR scan at shift bit 10
    wait_ready("abort");
    b = tms_log.size();
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 7'd32; cmd_data = '0;
    @(negedge aclk);
    cmd_valid = 1'b0;
    n = 0;
    while (tms_log.size() < b + 14 && n < 3000) begin @(negedge aclk); n++; end
    check("abort reached shift bit 10", tms_log.size() - b, 14);
    aresetn = 1'b0;
    #1;
    check("abort pins {tck,tms,rsp_valid,cmd_ready}", {jtag_tck, jtag_tms, rsp_valid, cmd_ready}, 4'b0100);
    repeat (3) @(negedge aclk);
    b = tms_log.size();
    hi0 = rsp_hi_cyc;
    aresetn = 1'b1;
    @(negedge aclk);
    wait_ready("abort autorst");
    check("abort autorst tck rises", tms_log.size() - b, 7);
    check("abort no response", rsp_hi_cyc - hi0, 0);
    b = tms_log.size();
    run_cmd("post-abort idcode", 2'd2, 7'd32, 64'h0, rsp, lat);
    check("post-abort idcode", rsp, {32'h0, IDCODE});
    check("post-abort tck rises", tms_log.size() - b, 37);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
